// File: rtl/multicycle_sequencer_pkg.sv
// Shared control constants for the multi-cycle MIPS sequencer:
// state codes, ALU op codes, opcode/funct values and the instruction classifier.
package multicycle_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_FAULT  = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_MUL = 3'd4
    } alu_e;

    typedef enum logic [2:0] {
        K_LW, K_SW, K_ADD, K_SUB, K_AND, K_OR, K_MUL, K_BAD
    } kind_e;

    localparam logic [5:0] OP_RTYPE = 6'b000001;
    localparam logic [5:0] OP_LW    = 6'b000010;
    localparam logic [5:0] OP_SW    = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_MUL = 6'b110010;

    function automatic kind_e classify(input logic [5:0] op,
                                       input logic [5:0] fn);
        kind_e k;
        k = K_BAD;
        unique case (1'b1)
            (op == OP_LW): k = K_LW;
            (op == OP_SW): k = K_SW;
            (op == OP_RTYPE && fn == FN_ADD): k = K_ADD;
            (op == OP_RTYPE && fn == FN_SUB): k = K_SUB;
            (op == OP_RTYPE && fn == FN_AND): k = K_AND;
            (op == OP_RTYPE && fn == FN_OR):  k = K_OR;
            (op == OP_RTYPE && fn == FN_MUL): k = K_MUL;
            default: k = K_BAD;
        endcase
        return k;
    endfunction

    function automatic alu_e alu_code(input kind_e k);
        alu_e a;
        a = ALU_ADD;
        unique case (1'b1)
            (k == K_SUB): a = ALU_SUB;
            (k == K_AND): a = ALU_AND;
            (k == K_OR):  a = ALU_OR;
            (k == K_MUL): a = ALU_MUL;
            default:      a = ALU_ADD;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/multicycle_sequencer_cycle_counter.sv
// Up-counter with synchronous clear and a terminal-count compare,
// shared between the MUL hold and the memory-ack timeout.
module multicycle_sequencer_cycle_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == last);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM: fetch over imem handshake, decode LW/SW/R-type,
// then step the datapath through EXEC/MEM/WB with one enable set per state.
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int WAIT_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [31:0] instr,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        ir_en,
    output logic        pc_en,
    output logic [2:0]  alu_op,
    output logic        alu_src_imm,
    output logic        mul_start,
    output logic        rf_we,
    output logic        rf_wsel,
    output logic        mem_to_reg,
    output logic [2:0]  state,
    output logic        busy,
    output logic        fault
);

    localparam int CMAX = (MUL_CYCLES > WAIT_LIMIT) ? MUL_CYCLES : WAIT_LIMIT;
    localparam int CW   = $clog2(CMAX) + 1;

    state_e        st;
    state_e        nxt;
    kind_e         kind;
    alu_e          alu_q;
    logic          tc;
    logic          clr;
    logic          cnt_en;
    logic [CW-1:0] last;
    logic          fetch_ok;
    logic          unused_instr;

    assign unused_instr = ^instr[25:6];
    assign fetch_ok     = (st == S_FETCH) && imem_ack;
    assign ir_en        = fetch_ok;
    assign pc_en        = fetch_ok;
    assign state        = st;
    assign alu_op       = alu_q;

    // EXEC only ever times the multiplier; FETCH/MEM time the ack wait
    assign last   = (st == S_EXEC) ? CW'(MUL_CYCLES - 1) : CW'(WAIT_LIMIT - 1);
    assign clr    = (nxt != st);
    assign cnt_en = (st == S_FETCH) || (st == S_MEM) || (st == S_EXEC);

    multicycle_sequencer_cycle_counter #(.W(CW)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .en   (cnt_en),
        .last (last),
        .tc   (tc)
    );

    always_comb begin
        nxt = st;
        unique case (st)
            S_IDLE:   nxt = run ? S_FETCH : S_IDLE;
            S_FETCH: begin
                if (imem_ack)  nxt = S_DECODE;
                else if (tc)   nxt = S_FAULT;
            end
            S_DECODE: nxt = (kind == K_BAD) ? S_FAULT : S_EXEC;
            S_EXEC: begin
                if (kind == K_LW || kind == K_SW) nxt = S_MEM;
                else if (kind != K_MUL || tc)     nxt = S_WB;
            end
            S_MEM: begin
                if (dmem_ack)  nxt = (kind == K_LW) ? S_WB
                                   : (run ? S_FETCH : S_IDLE);
                else if (tc)   nxt = S_FAULT;
            end
            S_WB:     nxt = run ? S_FETCH : S_IDLE;
            S_FAULT:  nxt = S_FAULT;
            default:  nxt = S_FAULT;
        endcase
    end

    // outputs are registered from the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            st          <= S_IDLE;
            kind        <= K_BAD;
            alu_q       <= ALU_ADD;
            imem_req    <= 1'b0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            alu_src_imm <= 1'b0;
            mul_start   <= 1'b0;
            rf_we       <= 1'b0;
            rf_wsel     <= 1'b0;
            mem_to_reg  <= 1'b0;
            busy        <= 1'b0;
            fault       <= 1'b0;
        end else begin
            st <= nxt;
            if (fetch_ok) begin
                kind <= classify(instr[31:26], instr[5:0]);
            end
            alu_q       <= (nxt == S_EXEC) ? alu_code(kind) : ALU_ADD;
            alu_src_imm <= (nxt == S_EXEC) && (kind == K_LW || kind == K_SW);
            mul_start   <= (nxt == S_EXEC) && (st == S_DECODE) && (kind == K_MUL);
            imem_req    <= (nxt == S_FETCH);
            dmem_req    <= (nxt == S_MEM);
            dmem_we     <= (nxt == S_MEM) && (kind == K_SW);
            rf_we       <= (nxt == S_WB);
            rf_wsel     <= (nxt == S_WB) && (kind != K_LW);
            mem_to_reg  <= (nxt == S_WB) && (kind == K_LW);
            busy        <= (nxt != S_IDLE) && (nxt != S_FAULT);
            fault       <= (nxt == S_FAULT);
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: per-instruction vector table
// plus hand sequences for fault stickiness, fetch timeout and reset in MEM.
module tb_multicycle_sequencer;

    logic        clk = 1'b0;
    logic        rst, run, imem_ack, dmem_ack;
    logic [31:0] instr;
    logic        imem_req, dmem_req, dmem_we, ir_en, pc_en;
    logic [2:0]  alu_op;
    logic        alu_src_imm, mul_start, rf_we, rf_wsel, mem_to_reg;
    logic [2:0]  state;
    logic        busy, fault;

    always #5 clk = ~clk;

    multicycle_sequencer #(.MUL_CYCLES(4), .WAIT_LIMIT(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .instr       (instr),
        .imem_ack    (imem_ack),
        .dmem_ack    (dmem_ack),
        .imem_req    (imem_req),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .ir_en       (ir_en),
        .pc_en       (pc_en),
        .alu_op      (alu_op),
        .alu_src_imm (alu_src_imm),
        .mul_start   (mul_start),
        .rf_we       (rf_we),
        .rf_wsel     (rf_wsel),
        .mem_to_reg  (mem_to_reg),
        .state       (state),
        .busy        (busy),
        .fault       (fault)
    );

    typedef struct {
        logic [31:0] instr;
        int run;
        int dly;
        int cyc;
        int fin;
        int rfwe;
        int rfwe_at;
        int wsel;
        int m2r;
        int dreq;
        int dwe;
        int mulst;
        int alu;
        int imm;
    } vec_t;

    localparam int NV = 13;
    vec_t vt[NV];
    int tests = 0;
    int fails = 0;

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        instr = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int c, mn, bad, irpc;
        int rfwe_n, rfwe_at, wsel, m2r, dreq, dwe, mulst, alu, imm;
        bit done;
        v = vt[i];
        c = 0; mn = 0; bad = 0; irpc = 0; done = 1'b0;
        rfwe_n = 0; rfwe_at = 0; wsel = 0; m2r = 0;
        dreq = 0; dwe = 0; mulst = 0; alu = 0; imm = 0;
        do_reset();
        check($sformatf("v%0d reset state", i), int'(state), 0);
        check($sformatf("v%0d reset busy", i), int'(busy), 0);
        run = 1'b1;
        instr = v.instr;
        imem_ack = 1'b1;
        @(posedge clk);
        #1 run = v.run[0];
        for (int k = 0; k < 40; k++) begin
            if (c > 0 && (state == 3'd1 || state == 3'd0 || state == 3'd6)) begin
                done = 1'b1;
                break;
            end
            c++;
            if (busy !== 1'b1) bad++;
            if (ir_en && pc_en) irpc++;
            if (rf_we) begin
                rfwe_n++;
                rfwe_at = c;
                wsel = int'(rf_wsel);
                m2r = int'(mem_to_reg);
            end
            if (dmem_req) dreq++;
            if (dmem_we) dwe++;
            if (mul_start) mulst++;
            if (state == 3'd3) begin
                alu = int'(alu_op);
                imm = int'(alu_src_imm);
            end else if (alu_op != 3'd0 || alu_src_imm) begin
                bad++;
            end
            if (state != 3'd4 && (dmem_req || dmem_we)) bad++;
            if (state == 3'd4) begin
                mn++;
                dmem_ack = (mn > v.dly);
            end else begin
                dmem_ack = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        check($sformatf("v%0d completed", i), int'(done), 1);
        check($sformatf("v%0d cycles", i), c, v.cyc);
        check($sformatf("v%0d end state", i), int'(state), v.fin);
        check($sformatf("v%0d fault", i), int'(fault), (v.fin == 6) ? 1 : 0);
        check($sformatf("v%0d ir_en/pc_en", i), irpc, 1);
        check($sformatf("v%0d rf_we count", i), rfwe_n, v.rfwe);
        check($sformatf("v%0d rf_we cycle", i), rfwe_at, v.rfwe_at);
        check($sformatf("v%0d rf_wsel", i), wsel, v.wsel);
        check($sformatf("v%0d mem_to_reg", i), m2r, v.m2r);
        check($sformatf("v%0d dmem_req cycles", i), dreq, v.dreq);
        check($sformatf("v%0d dmem_we cycles", i), dwe, v.dwe);
        check($sformatf("v%0d mul_start pulses", i), mulst, v.mulst);
        check($sformatf("v%0d alu_op", i), alu, v.alu);
        check($sformatf("v%0d alu_src_imm", i), imm, v.imm);
        check($sformatf("v%0d stray outputs", i), bad, 0);
    endtask

    initial begin
        //        instr         run dly cyc fin rfwe at wsel m2r dreq dwe mul alu imm
        vt[0]  = '{32'h04431820, 1, 0,  4, 1, 1,  4, 1, 0, 0, 0, 0, 0, 0};
        vt[1]  = '{32'h04000022, 1, 0,  4, 1, 1,  4, 1, 0, 0, 0, 0, 1, 0};
        vt[2]  = '{32'h04000024, 1, 0,  4, 1, 1,  4, 1, 0, 0, 0, 0, 2, 0};
        vt[3]  = '{32'h04000025, 0, 0,  4, 0, 1,  4, 1, 0, 0, 0, 0, 3, 0};
        vt[4]  = '{32'h08A10010, 1, 3,  8, 1, 1,  8, 0, 1, 4, 0, 0, 0, 1};
        vt[5]  = '{32'h08A10010, 0, 0,  5, 0, 1,  5, 0, 1, 1, 0, 0, 0, 1};
        vt[6]  = '{32'h0CA10004, 0, 0,  4, 0, 0,  0, 0, 0, 1, 1, 0, 0, 1};
        vt[7]  = '{32'h0CA10004, 1, 2,  6, 1, 0,  0, 0, 0, 3, 3, 0, 0, 1};
        vt[8]  = '{32'h04000032, 1, 0,  7, 1, 1,  7, 1, 0, 0, 0, 1, 4, 0};
        vt[9]  = '{32'h1C000020, 1, 0,  2, 6, 0,  0, 0, 0, 0, 0, 0, 0, 0};
        vt[10] = '{32'h04000000, 1, 0,  2, 6, 0,  0, 0, 0, 0, 0, 0, 0, 0};
        vt[11] = '{32'h08A10010, 1, 7, 12, 1, 1, 12, 0, 1, 8, 0, 0, 0, 1};
        vt[12] = '{32'h08A10010, 1, 8, 11, 6, 0,  0, 0, 0, 8, 0, 0, 0, 1};

        for (int i = 0; i < NV; i++) begin
            run_vec(i);
        end

        // illegal opcode: fault is sticky under run=1, only rst clears it
        do_reset();
        run = 1'b1;
        instr = 32'h1C000020;
        imem_ack = 1'b1;
        repeat (3) @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        check("sticky state", int'(state), 6);
        check("sticky fault", int'(fault), 1);
        check("sticky busy", int'(busy), 0);
        check("sticky imem_req", int'(imem_req), 0);
        check("sticky ir_en", int'(ir_en), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("fault rst state", int'(state), 0);
        check("fault rst fault", int'(fault), 0);
        rst = 1'b0;

        // no imem ack: FETCH holds 8 cycles, FAULT on cycle 9
        do_reset();
        run = 1'b1;
        @(posedge clk);
        #1;
        check("to c1 state", int'(state), 1);
        check("to c1 imem_req", int'(imem_req), 1);
        repeat (7) @(posedge clk);
        #1;
        check("to c8 state", int'(state), 1);
        check("to c8 imem_req", int'(imem_req), 1);
        @(posedge clk);
        #1;
        check("to c9 state", int'(state), 6);
        check("to c9 fault", int'(fault), 1);

        // ack arriving on the last allowed fetch cycle still proceeds
        do_reset();
        run = 1'b1;
        @(posedge clk);
        repeat (7) @(posedge clk);
        #1;
        instr = 32'h04000020;
        imem_ack = 1'b1;
        #1;
        check("ack8 ir_en", int'(ir_en), 1);
        check("ack8 pc_en", int'(pc_en), 1);
        @(posedge clk);
        #1;
        imem_ack = 1'b0;
        check("ack8 state", int'(state), 2);
        check("ack8 ir_en after", int'(ir_en), 0);

        // reset while waiting in MEM
        do_reset();
        run = 1'b1;
        instr = 32'h08A10010;
        imem_ack = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("mem rst pre state", int'(state), 4);
        check("mem rst pre dmem_req", int'(dmem_req), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mem rst state", int'(state), 0);
        check("mem rst dmem_req", int'(dmem_req), 0);
        check("mem rst busy", int'(busy), 0);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
